// File: rtl/vga_sram_pkg.sv
// Shared definitions for the VGA frame-buffer SRAM path: arbiter states,
// default bus widths and frame-buffer placement used by the VGA fetch logic.
package vga_sram_pkg;

   localparam int ADDR_W_DEF = 20;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_TURN = 2'd3
   } state_e;

   // 640x480 at one 16-bit word per pixel; two frames fit in the 1M-word part.
   localparam int              FRAME_W     = 640;
   localparam int              FRAME_H     = 480;
   localparam int              FRAME_WORDS = FRAME_W * FRAME_H;
   localparam logic [ADDR_W_DEF-1:0] FB0_BASE = 20'h00000;
   localparam logic [ADDR_W_DEF-1:0] FB1_BASE = 20'h4B000;

endpackage

// File: rtl/vga_sram_arbiter.sv
// Single-port async SRAM arbiter: VGA reads take priority, frame-loader writes
// are guaranteed a slot after MAX_RD_STREAK consecutive reads.
module vga_sram_arbiter
   import vga_sram_pkg::*;
#(
   parameter int ACCESS_CYCLES = 2,
   parameter int MAX_RD_STREAK = 4,
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int DATA_W        = DATA_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_rd_valid,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic              o_rd_ready,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_valid,
   input  logic              i_wr_valid,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_ready,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [DATA_W-1:0] o_sram_dq_out,
   output logic              o_sram_dq_oe,
   input  logic [DATA_W-1:0] i_sram_dq,
   output logic              o_sram_ce_n,
   output logic              o_sram_oe_n,
   output logic              o_sram_we_n,
   output logic              o_sram_ub_n,
   output logic              o_sram_lb_n
);

   localparam int CNT_W = $clog2(ACCESS_CYCLES);
   localparam int STK_W = $clog2(MAX_RD_STREAK + 1) > 0 ? $clog2(MAX_RD_STREAK + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
   localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_RD_STREAK);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [STK_W-1:0]   streak_q, streak_d;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  dq_out_q, rd_data_q;
   logic               rd_valid_q;
   logic               ce_n_q, oe_n_q, we_n_q, dq_oe_q;
   logic               ce_n_d, oe_n_d, we_n_d, dq_oe_d;
   logic               win, gnt_rd, gnt_wr, rd_done;

   always_comb begin
      win    = (state_q == ST_IDLE) ||
               (((state_q == ST_RD) || (state_q == ST_WR)) && (cnt_q == CNT_LAST));
      gnt_rd = win && i_rd_valid && !(i_wr_valid && (streak_q >= STK_MAX));
      gnt_wr = win && i_wr_valid && !gnt_rd;
      rd_done = (state_q == ST_RD) && (cnt_q == CNT_LAST);
   end

   assign o_rd_ready = gnt_rd;
   assign o_wr_ready = gnt_wr;

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      if (gnt_rd) begin
         // Bus was being driven by us; give the pad one idle cycle before OE.
         state_d = (state_q == ST_WR) ? ST_TURN : ST_RD;
      end else if (gnt_wr) begin
         state_d = ST_WR;
      end else if (win) begin
         state_d = ST_IDLE;
      end else if (state_q == ST_TURN) begin
         state_d = ST_RD;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      streak_d = streak_q;
      if (!i_wr_valid || gnt_wr) begin
         streak_d = '0;
      end else if (gnt_rd && (streak_q != STK_MAX)) begin
         streak_d = streak_q + 1'b1;
      end
   end

   // Strobes come straight from flops so the pads never see decode glitches.
   always_comb begin
      ce_n_d  = !((state_d == ST_RD) || (state_d == ST_WR));
      oe_n_d  = (state_d != ST_RD);
      we_n_d  = !((state_d == ST_WR) && (cnt_d != CNT_LAST));
      dq_oe_d = (state_d == ST_WR);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         streak_q   <= '0;
         addr_q     <= '0;
         dq_out_q   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         ce_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         we_n_q     <= 1'b1;
         dq_oe_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         streak_q   <= streak_d;
         ce_n_q     <= ce_n_d;
         oe_n_q     <= oe_n_d;
         we_n_q     <= we_n_d;
         dq_oe_q    <= dq_oe_d;
         rd_valid_q <= rd_done;
         if (rd_done) rd_data_q <= i_sram_dq;
         if (gnt_rd) begin
            addr_q <= i_rd_addr;
         end else if (gnt_wr) begin
            addr_q   <= i_wr_addr;
            dq_out_q <= i_wr_data;
         end
      end
   end

   assign o_sram_addr   = addr_q;
   assign o_sram_dq_out = dq_out_q;
   assign o_sram_dq_oe  = dq_oe_q;
   assign o_sram_ce_n   = ce_n_q;
   assign o_sram_oe_n   = oe_n_q;
   assign o_sram_we_n   = we_n_q;
   assign o_sram_ub_n   = ce_n_q;
   assign o_sram_lb_n   = ce_n_q;
   assign o_rd_data     = rd_data_q;
   assign o_rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// Directed bench for vga_sram_arbiter with a behavioural async SRAM model.
module tb_vga_sram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_valid, wr_valid;
   logic [19:0] rd_addr, wr_addr;
   logic [15:0] wr_data;
   logic        rd_ready, wr_ready, rd_vld;
   logic [15:0] rd_data;
   logic [19:0] sram_addr;
   logic [15:0] dq_out, sram_dq;
   logic        dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int we_low   = 0;
   int conflicts = 0;
   logic [15:0] rdq[$];

   logic        pre_we;
   logic [11:0] pre_addr;
   logic [15:0] pre_data;
   logic [15:0] mem [0:4095];

   vga_sram_arbiter #(.ACCESS_CYCLES(2), .MAX_RD_STREAK(4), .ADDR_W(20), .DATA_W(16)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_rd_valid(rd_valid), .i_rd_addr(rd_addr), .o_rd_ready(rd_ready),
      .o_rd_data(rd_data), .o_rd_valid(rd_vld),
      .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
      .o_sram_addr(sram_addr), .o_sram_dq_out(dq_out), .o_sram_dq_oe(dq_oe), .i_sram_dq(sram_dq),
      .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
      .o_sram_ub_n(ub_n), .o_sram_lb_n(lb_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (!ce_n && !we_n && dq_oe) mem[sram_addr[11:0]] <= dq_out;
   end

   assign sram_dq = (!ce_n && !oe_n) ? mem[sram_addr[11:0]] : 16'h0000;

   always @(negedge clk) begin
      if (rd_vld) rdq.push_back(rd_data);
      if (!we_n) we_low <= we_low + 1;
      if (dq_oe && !oe_n) conflicts <= conflicts + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic preload(input logic [11:0] a, input logic [15:0] d);
      @(negedge clk); pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clk); pre_we = 1'b0;
   endtask

   // Presents a read at the current negedge; returns data and acceptance-to-valid latency.
   task automatic do_read(input logic [19:0] a, output logic [15:0] d, output int lat, output bit ok);
      int t0;
      bit acc;
      ok = 0; acc = 0; lat = -1; d = '0; t0 = 0;
      rd_valid = 1'b1; rd_addr = a;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (rd_ready) begin acc = 1; t0 = cyc; break; end
         @(negedge clk);
      end
      @(negedge clk);
      rd_valid = 1'b0;
      if (acc) begin
         for (int i = 0; i < 10; i++) begin
            if (rd_vld) begin ok = 1; d = rd_data; lat = cyc - t0; break; end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; rd_valid = 0; wr_valid = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
      pre_we = 0; pre_addr = '0; pre_data = '0;
      preload(12'h123, 16'hBEEF);
      preload(12'h010, 16'h0000);
      for (int i = 0; i < 8; i++) preload(12'(i), 16'h1000 + 16'(i));
      @(negedge clk);
      checks++; if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'b11111) begin failures++;
         $display("FAIL rst_strobes got=%b exp=11111", {ce_n, oe_n, we_n, ub_n, lb_n}); end
      checks++; if (dq_oe !== 1'b0) begin failures++; $display("FAIL rst_dq_oe got=%b exp=0", dq_oe); end
      checks++; if (sram_addr !== 20'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", sram_addr); end
      checks++; if (dq_out !== 16'h0) begin failures++; $display("FAIL rst_dq_out got=%h exp=0", dq_out); end
      checks++; if ({rd_vld, rd_data} !== 17'h0) begin failures++;
         $display("FAIL rst_rd_out got=%b/%h exp=0/0", rd_vld, rd_data); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_read;
      rd_valid = 1'b1; rd_addr = 20'h00123;
      #1;
      checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL sr_ready got=%b exp=1", rd_ready); end
      @(negedge clk);  // t+1
      rd_valid = 1'b0;
      checks++; if ({ce_n, oe_n, we_n, dq_oe} !== 4'b0010) begin failures++;
         $display("FAIL sr_strobe_t1 got=%b exp=0010", {ce_n, oe_n, we_n, dq_oe}); end
      checks++; if (sram_addr !== 20'h00123) begin failures++; $display("FAIL sr_addr got=%h exp=00123", sram_addr); end
      @(negedge clk);  // t+2
      checks++; if ({oe_n, rd_vld} !== 2'b00) begin failures++;
         $display("FAIL sr_t2 got oe_n/vld=%b exp=00", {oe_n, rd_vld}); end
      @(negedge clk);  // t+3
      checks++; if (rd_vld !== 1'b1 || rd_data !== 16'hBEEF) begin failures++;
         $display("FAIL sr_data got=%b/%h exp=1/beef", rd_vld, rd_data); end
      checks++; if (oe_n !== 1'b1) begin failures++; $display("FAIL sr_oe_release got=%b exp=1", oe_n); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_streaming_reads;
      int gc[8];
      int base, we0, bad_sp;
      bit ok;
      base = rdq.size(); we0 = we_low; bad_sp = 0;
      rd_valid = 1'b1;
      for (int a = 0; a < 8; a++) begin
         rd_addr = 20'(a); ok = 0; gc[a] = -100;
         for (int i = 0; i < 10; i++) begin
            #1;
            if (rd_ready) begin ok = 1; gc[a] = cyc; break; end
            @(negedge clk);
         end
         @(negedge clk);
      end
      rd_valid = 1'b0;
      repeat (6) @(negedge clk);
      for (int a = 1; a < 8; a++) if (gc[a] - gc[a-1] != 2) bad_sp++;
      checks++; if (bad_sp != 0) begin failures++; $display("FAIL st_spacing got=%0d bad gaps exp=0", bad_sp); end
      checks++; if (rdq.size() - base != 8) begin failures++;
         $display("FAIL st_count got=%0d exp=8", rdq.size() - base); end
      for (int a = 0; a < 8; a++) begin
         if (base + a < rdq.size()) begin
            checks++; if (rdq[base + a] !== 16'h1000 + 16'(a)) begin failures++;
               $display("FAIL st_data[%0d] got=%h exp=%h", a, rdq[base + a], 16'h1000 + 16'(a)); end
         end
      end
      checks++; if (we_low != we0) begin failures++; $display("FAIL st_we_n got=%0d low cycles exp=0", we_low - we0); end
   endtask

   task automatic test_starvation;
      int nrd, both;
      bit got, ok;
      logic [15:0] d;
      int lat;
      nrd = 0; both = 0; got = 0;
      rd_valid = 1'b1; rd_addr = 20'h00020;
      wr_valid = 1'b1; wr_addr = 20'h00010; wr_data = 16'h5A5A;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (rd_ready && wr_ready) both++;
         if (wr_ready) begin got = 1; break; end
         if (rd_ready) nrd++;
         @(negedge clk);
      end
      @(negedge clk);
      rd_valid = 1'b0; wr_valid = 1'b0;
      checks++; if (got !== 1'b1) begin failures++; $display("FAIL sv_wr_granted got=%b exp=1", got); end
      checks++; if (nrd != 4) begin failures++; $display("FAIL sv_rd_grants got=%0d exp=4", nrd); end
      checks++; if (both != 0) begin failures++; $display("FAIL sv_both_ready got=%0d exp=0", both); end
      repeat (4) @(negedge clk);
      do_read(20'h00010, d, lat, ok);
      checks++; if (!ok || d !== 16'h5A5A) begin failures++; $display("FAIL sv_readback got=%h ok=%b exp=5a5a", d, ok); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_turnaround;
      wr_valid = 1'b1; wr_addr = 20'h00030; wr_data = 16'h1234;
      for (int i = 0; i < 10; i++) begin #1; if (wr_ready) break; @(negedge clk); end
      @(negedge clk);  // t+1: WR, we_n low
      wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 20'h00030;
      checks++; if ({ce_n, oe_n, we_n, dq_oe} !== 4'b0101) begin failures++;
         $display("FAIL ta_wr1 got=%b exp=0101", {ce_n, oe_n, we_n, dq_oe}); end
      @(negedge clk);  // t+2: WR last cycle
      checks++; if ({ce_n, oe_n, we_n, dq_oe} !== 4'b0111) begin failures++;
         $display("FAIL ta_wr2 got=%b exp=0111", {ce_n, oe_n, we_n, dq_oe}); end
      #1;
      checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL ta_rd_ready got=%b exp=1", rd_ready); end
      @(negedge clk);  // t+3: TURN
      rd_valid = 1'b0;
      checks++; if ({ce_n, oe_n, we_n, ub_n, lb_n, dq_oe} !== 6'b111110) begin failures++;
         $display("FAIL ta_turn got=%b exp=111110", {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe}); end
      @(negedge clk);  // t+4: RD
      checks++; if ({ce_n, oe_n, we_n, dq_oe} !== 4'b0010) begin failures++;
         $display("FAIL ta_rd got=%b exp=0010", {ce_n, oe_n, we_n, dq_oe}); end
      repeat (2) @(negedge clk);  // t+6
      checks++; if (rd_vld !== 1'b1 || rd_data !== 16'h1234) begin failures++;
         $display("FAIL ta_data got=%b/%h exp=1/1234", rd_vld, rd_data); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_rd_to_wr;
      rd_valid = 1'b1; rd_addr = 20'h00030;
      for (int i = 0; i < 10; i++) begin #1; if (rd_ready) break; @(negedge clk); end
      @(negedge clk);  // t+1
      rd_valid = 1'b0; wr_valid = 1'b1; wr_addr = 20'h00031; wr_data = 16'h4321;
      @(negedge clk);  // t+2
      #1;
      checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL rw_wr_ready got=%b exp=1", wr_ready); end
      @(negedge clk);  // t+3: WR directly, no gap
      wr_valid = 1'b0;
      checks++; if ({ce_n, oe_n, we_n, dq_oe} !== 4'b0101) begin failures++;
         $display("FAIL rw_no_gap got=%b exp=0101", {ce_n, oe_n, we_n, dq_oe}); end
      checks++; if (rd_vld !== 1'b1 || rd_data !== 16'h1234) begin failures++;
         $display("FAIL rw_rd_data got=%b/%h exp=1/1234", rd_vld, rd_data); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_write_shape;
      int we0, lat;
      bit ok;
      logic [15:0] d;
      we0 = we_low;
      wr_valid = 1'b1; wr_addr = 20'h00040; wr_data = 16'hA5C3;
      for (int i = 0; i < 10; i++) begin #1; if (wr_ready) break; @(negedge clk); end
      @(negedge clk);  // t+1
      wr_valid = 1'b0; wr_data = 16'h0000; wr_addr = 20'h0;
      checks++; if ({ce_n, oe_n, we_n, dq_oe} !== 4'b0101 || sram_addr !== 20'h00040 || dq_out !== 16'hA5C3) begin
         failures++; $display("FAIL ws_t1 got=%b %h %h exp=0101 00040 a5c3", {ce_n, oe_n, we_n, dq_oe}, sram_addr, dq_out); end
      @(negedge clk);  // t+2: we_n high, bus held
      checks++; if ({ce_n, oe_n, we_n, dq_oe} !== 4'b0111 || sram_addr !== 20'h00040 || dq_out !== 16'hA5C3) begin
         failures++; $display("FAIL ws_hold got=%b %h %h exp=0111 00040 a5c3", {ce_n, oe_n, we_n, dq_oe}, sram_addr, dq_out); end
      @(negedge clk);  // t+3
      checks++; if ({ce_n, dq_oe} !== 2'b10) begin failures++; $display("FAIL ws_end got=%b exp=10", {ce_n, dq_oe}); end
      checks++; if (we_low - we0 != 1) begin failures++; $display("FAIL ws_we_len got=%0d exp=1", we_low - we0); end
      do_read(20'h00040, d, lat, ok);
      checks++; if (!ok || d !== 16'hA5C3) begin failures++; $display("FAIL ws_readback got=%h ok=%b exp=a5c3", d, ok); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_read;
      int base, lat;
      bit ok;
      logic [15:0] d;
      base = rdq.size();
      rd_valid = 1'b1; rd_addr = 20'h00123;
      for (int i = 0; i < 10; i++) begin #1; if (rd_ready) break; @(negedge clk); end
      @(negedge clk);  // t+1: first RD cycle
      rd_valid = 1'b0;
      checks++; if (oe_n !== 1'b0) begin failures++; $display("FAIL rm_started got=%b exp=0", oe_n); end
      rst = 1'b1;
      #1;
      checks++; if ({ce_n, oe_n, we_n, ub_n, lb_n, dq_oe} !== 6'b111110) begin failures++;
         $display("FAIL rm_async got=%b exp=111110", {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe}); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (rdq.size() != base) begin failures++;
         $display("FAIL rm_no_valid got=%0d pulses exp=0", rdq.size() - base); end
      do_read(20'h00123, d, lat, ok);
      checks++; if (!ok || d !== 16'hBEEF || lat != 3) begin failures++;
         $display("FAIL rm_recover got=%h lat=%0d ok=%b exp=beef lat=3", d, lat, ok); end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_streaming_reads();
      test_starvation();
      test_turnaround();
      test_rd_to_wr();
      test_write_shape();
      test_reset_mid_read();
      @(negedge clk);
      checks++; if (conflicts != 0) begin failures++; $display("FAIL oe_dq_conflict got=%0d exp=0", conflicts); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
